// File: rtl/jelly_bean_pkg.sv
// Shared types for the jelly bean arbiter: bus commands, tastes, field widths and arbiter states.
package jelly_bean_pkg;

  localparam int FLAVOR_W = 3;
  localparam int COLOR_W  = 2;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    NO_OP = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } command_e;

  typedef enum logic [1:0] {
    UNKNOWN = 2'd0,
    YUMMY   = 2'd1,
    YUCKY   = 2'd2
  } taste_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [FLAVOR_W-1:0] flavor;
    logic [COLOR_W-1:0]  color;
    logic                sugar_free;
    logic                sour;
    command_e            command;
  } jb_req_t;

endpackage

// File: rtl/jelly_bean_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after last_i, wrapping modulo N.
module rr_picker #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] last_i,
  output logic [N-1:0]   grant_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  logic [IDW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(last_i) + k) % N);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/jelly_bean_arbiter.sv
// Round-robin arbiter sharing one jelly bean slave among NUM_REQ requesters;
// one transaction in flight at a time, READ taste is returned to the granted requester.
module jelly_bean_arbiter
  import jelly_bean_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int RESP_LAT = 1,
  parameter int IDW      = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*FLAVOR_W-1:0]  req_flavor_i,
  input  logic [NUM_REQ*COLOR_W-1:0]   req_color_i,
  input  logic [NUM_REQ-1:0]           req_sugar_free_i,
  input  logic [NUM_REQ-1:0]           req_sour_i,
  input  logic [NUM_REQ*2-1:0]         req_command_i,
  output logic                         rsp_valid_o,
  output logic [IDW-1:0]               rsp_id_o,
  output logic [1:0]                   rsp_taste_o,
  output logic [FLAVOR_W-1:0]          jb_flavor_o,
  output logic [COLOR_W-1:0]           jb_color_o,
  output logic                         jb_sugar_free_o,
  output logic                         jb_sour_o,
  output logic [1:0]                   jb_command_o,
  input  logic [1:0]                   jb_taste_i
);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  jb_req_t          bus_q, bus_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  taste_e           rsp_taste_q, rsp_taste_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;

  logic [FLAVOR_W-1:0] win_flavor;
  logic [COLOR_W-1:0]  win_color;
  logic                win_sugar_free;
  logic                win_sour;
  logic [1:0]          win_command;

  rr_picker #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_pick (
    .req_i   (req_valid_i),
    .last_i  (last_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign win_flavor     = req_flavor_i[int'(pick_idx)*FLAVOR_W +: FLAVOR_W];
  assign win_color      = req_color_i[int'(pick_idx)*COLOR_W +: COLOR_W];
  assign win_sugar_free = req_sugar_free_i[pick_idx];
  assign win_sour       = req_sour_i[pick_idx];
  assign win_command    = req_command_i[int'(pick_idx)*2 +: 2];

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    bus_d       = bus_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_taste_d = rsp_taste_q;
    req_ready_o = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any && !rst) begin
          req_ready_o = pick_grant;
          last_d      = pick_idx;
          // NO_OP and the reserved code are consumed here without touching the bus.
          if (win_command == READ || win_command == WRITE) begin
            bus_d.flavor     = win_flavor;
            bus_d.color      = win_color;
            bus_d.sugar_free = win_sugar_free;
            bus_d.sour       = win_sour;
            bus_d.command    = command_e'(win_command);
            id_d             = pick_idx;
            state_d          = ISSUE;
          end
        end
      end
      ISSUE: begin
        bus_d.command = NO_OP;
        cnt_d         = CNT_W'(1);
        state_d       = (bus_q.command == READ) ? WAIT : IDLE;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(RESP_LAT)) begin
          rsp_taste_d = taste_e'(jb_taste_i);
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NUM_REQ - 1);
      id_q        <= '0;
      cnt_q       <= '0;
      bus_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_taste_q <= UNKNOWN;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      bus_q       <= bus_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_taste_q <= rsp_taste_d;
    end
  end

  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_id_o        = rsp_id_q;
  assign rsp_taste_o     = rsp_taste_q;
  assign jb_flavor_o     = bus_q.flavor;
  assign jb_color_o      = bus_q.color;
  assign jb_sugar_free_o = bus_q.sugar_free;
  assign jb_sour_o       = bus_q.sour;
  assign jb_command_o    = bus_q.command;

endmodule

// File: tb/tb_jelly_bean_arbiter.sv
// Bench for jelly_bean_arbiter: two instances (RESP_LAT 1 and 3) driven by requester agents,
// checked by a transaction-level model feeding bus/response scoreboards.
module tb_jelly_bean_arbiter;
  import jelly_bean_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   rv   [2];
  logic [N*3-1:0] rfl  [2];
  logic [N*2-1:0] rco  [2];
  logic [N-1:0]   rsf  [2];
  logic [N-1:0]   rso  [2];
  logic [N*2-1:0] rcmd [2];
  logic [1:0]     taste[2];

  logic [N-1:0]   rdy  [2];
  logic           rspv [2];
  logic [IDW-1:0] rspid[2];
  logic [1:0]     rspt [2];
  logic [2:0]     jfl  [2];
  logic [1:0]     jco  [2];
  logic           jsf  [2];
  logic           jso  [2];
  logic [1:0]     jcmd [2];

  jelly_bean_arbiter #(.NUM_REQ(N), .RESP_LAT(1), .IDW(IDW)) u_dut_lat1 (
    .clk(clk), .rst(rst),
    .req_valid_i(rv[0]), .req_ready_o(rdy[0]), .req_flavor_i(rfl[0]), .req_color_i(rco[0]),
    .req_sugar_free_i(rsf[0]), .req_sour_i(rso[0]), .req_command_i(rcmd[0]),
    .rsp_valid_o(rspv[0]), .rsp_id_o(rspid[0]), .rsp_taste_o(rspt[0]),
    .jb_flavor_o(jfl[0]), .jb_color_o(jco[0]), .jb_sugar_free_o(jsf[0]), .jb_sour_o(jso[0]),
    .jb_command_o(jcmd[0]), .jb_taste_i(taste[0])
  );

  jelly_bean_arbiter #(.NUM_REQ(N), .RESP_LAT(3), .IDW(IDW)) u_dut_lat3 (
    .clk(clk), .rst(rst),
    .req_valid_i(rv[1]), .req_ready_o(rdy[1]), .req_flavor_i(rfl[1]), .req_color_i(rco[1]),
    .req_sugar_free_i(rsf[1]), .req_sour_i(rso[1]), .req_command_i(rcmd[1]),
    .rsp_valid_o(rspv[1]), .rsp_id_o(rspid[1]), .rsp_taste_o(rspt[1]),
    .jb_flavor_o(jfl[1]), .jb_color_o(jco[1]), .jb_sugar_free_o(jsf[1]), .jb_sour_o(jso[1]),
    .jb_command_o(jcmd[1]), .jb_taste_i(taste[1])
  );

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // ---------------- reference model and scoreboards ----------------
  typedef struct { int cyc; int cmd; int fields; } bus_t;
  typedef struct { int cyc; int id; int taste; } rsp_t;

  bus_t bq[2][$];
  rsp_t rq[2][$];
  int   ptr[2]      = '{N-1, N-1};
  int   free_at[2]  = '{0, 0};
  int   samp_cyc[2] = '{-1, -1};
  int   samp_id[2]  = '{0, 0};
  int   cyc         = 0;
  int   n_checks    = 0;
  int   n_fail      = 0;
  bit   done        = 1'b0;
  int   tmo         = 0;
  bit   renew       = 1'b0;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (lat%0d, cycle %0d): got %0d, expected %0d", nm, lat(k), cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        chk("reset_outputs", k,
            int'({rdy[k], rspv[k], rspid[k], rspt[k], jfl[k], jco[k], jsf[k], jso[k], jcmd[k]}), 0);
        ptr[k]      = N - 1;
        free_at[k]  = 0;
        samp_cyc[k] = -1;
        bq[k].delete();
        rq[k].delete();
      end else begin
        int win;
        int cmd;
        bus_t b;
        rsp_t r;
        win = -1;
        if (cyc >= free_at[k]) begin
          for (int s = 1; s <= N; s++) begin
            int c;
            c = (ptr[k] + s) % N;
            if (win < 0 && rv[k][c]) win = c;
          end
        end
        chk("req_ready", k, int'(rdy[k]), (win >= 0) ? (1 << win) : 0);

        if (jcmd[k] != 2'd0) begin
          if (bq[k].size() == 0) chk("bus_unexpected", k, int'(jcmd[k]), 0);
          else begin
            b = bq[k].pop_front();
            chk("bus_cycle", k, cyc, b.cyc);
            chk("bus_cmd", k, int'(jcmd[k]), b.cmd);
            chk("bus_fields", k, int'({jfl[k], jco[k], jsf[k], jso[k]}), b.fields);
          end
        end else if (bq[k].size() > 0 && bq[k][0].cyc <= cyc) begin
          b = bq[k].pop_front();
          chk("bus_missing", k, 0, b.cmd);
        end

        if (samp_cyc[k] == cyc) begin
          r.cyc = cyc + 1; r.id = samp_id[k]; r.taste = int'(taste[k]);
          rq[k].push_back(r);
        end

        if (rspv[k]) begin
          if (rq[k].size() == 0) chk("rsp_unexpected", k, 1, 0);
          else begin
            r = rq[k].pop_front();
            chk("rsp_cycle", k, cyc, r.cyc);
            chk("rsp_id", k, int'(rspid[k]), r.id);
            chk("rsp_taste", k, int'(rspt[k]), r.taste);
          end
        end else if (rq[k].size() > 0 && rq[k][0].cyc <= cyc) begin
          r = rq[k].pop_front();
          chk("rsp_missing", k, 0, 1);
        end

        if (win >= 0) begin
          ptr[k] = win;
          cmd = int'(rcmd[k][win*2 +: 2]);
          if (cmd == int'(READ) || cmd == int'(WRITE)) begin
            b.cyc = cyc + 1; b.cmd = cmd;
            b.fields = int'({rfl[k][win*3 +: 3], rco[k][win*2 +: 2], rsf[k][win], rso[k][win]});
            bq[k].push_back(b);
          end
          if (cmd == int'(READ)) begin
            samp_cyc[k] = cyc + 1 + lat(k);
            samp_id[k]  = win;
            free_at[k]  = cyc + lat(k) + 3;
          end else if (cmd == int'(WRITE)) begin
            free_at[k] = cyc + 2;
          end else begin
            free_at[k] = cyc + 1;
          end
        end
      end
    end
    cyc++;
    if (done) begin
      chk("scoreboards_drained", 0, bq[0].size() + bq[1].size() + rq[0].size() + rq[1].size(), 0);
      chk("agent_timeouts", 0, tmo, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  // ---------------- requester agents ----------------
  task automatic tick();
    logic [N-1:0] hs[2];
    @(negedge clk);
    hs[0] = rdy[0];
    hs[1] = rdy[1];
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!renew) rv[k] = rv[k] & ~hs[k];
      taste[k] = 2'($urandom_range(0, 2));
    end
  endtask

  task automatic set_req(input int k, input int r, input int cmd, input int fl, input int co,
                         input int sf, input int so);
    rv[k][r]         = 1'b1;
    rfl[k][r*3 +: 3] = 3'(fl);
    rco[k][r*2 +: 2] = 2'(co);
    rsf[k][r]        = 1'(sf);
    rso[k][r]        = 1'(so);
    rcmd[k][r*2 +: 2] = 2'(cmd);
  endtask

  task automatic req(input int r, input int cmd, input int fl, input int co, input int sf, input int so);
    for (int k = 0; k < 2; k++) set_req(k, r, cmd, fl, co, sf, so);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((rv[0] != '0 || rv[1] != '0) && n < 60) begin
      tick();
      n++;
    end
    if (rv[0] != '0 || rv[1] != '0) begin
      tmo++;
      rv[0] = '0;
      rv[1] = '0;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    rv[0] = '0;
    rv[1] = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rv[k] = '0; rfl[k] = '0; rco[k] = '0; rsf[k] = '0; rso[k] = '0; rcmd[k] = '0;
      taste[k] = 2'd1;
    end
    repeat (3) tick();
    rst = 1'b0;

    // single READ from requester 2
    req(2, int'(READ), 3, 1, 0, 1);
    wait_idle();
    repeat (8) tick();

    // all four requesters stream WRITEs
    for (int r = 0; r < N; r++) req(r, int'(WRITE), r + 4, r, r % 2, 1);
    renew = 1'b1;
    repeat (12) tick();
    renew = 1'b0;
    wait_idle();
    repeat (4) tick();

    // NO_OP from requester 1 is consumed; requester 2 follows
    do_reset();
    req(1, int'(NO_OP), 7, 3, 1, 1);
    req(2, int'(WRITE), 2, 2, 1, 0);
    wait_idle();
    repeat (4) tick();

    // reset while a READ is waiting for its taste
    req(1, int'(READ), 5, 2, 1, 0);
    repeat (2) tick();
    #1 rst = 1'b1;
    rv[0] = '0;
    rv[1] = '0;
    repeat (2) tick();
    rst = 1'b0;
    req(2, int'(WRITE), 1, 1, 0, 0);
    req(0, int'(WRITE), 6, 3, 1, 1);
    wait_idle();
    repeat (4) tick();

    // requester 3 withdraws before being considered; requester 0 wins
    req(1, int'(READ), 4, 0, 0, 1);
    tick();
    req(3, int'(WRITE), 3, 3, 1, 1);
    req(0, int'(READ), 2, 1, 1, 0);
    tick();
    rv[0][3] = 1'b0;
    rv[1][3] = 1'b0;
    wait_idle();
    repeat (8) tick();

    // randomized traffic, independent per instance
    for (int t = 0; t < 1500; t++) begin
      for (int k = 0; k < 2; k++) begin
        for (int r = 0; r < N; r++) begin
          if (!rv[k][r]) begin
            if ($urandom_range(0, 2) == 0)
              set_req(k, r, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
          end else if ($urandom_range(0, 19) == 0) begin
            rv[k][r] = 1'b0;
          end
        end
      end
      tick();
    end
    rv[0] = '0;
    rv[1] = '0;
    repeat (15) tick();
    done = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
